// File: rtl/v0_intc_pkg.sv
// ---------------------------------------------------------------------------
// v0_intc_pkg
// Shared definitions for the v0 interrupt controller:
//   - Wishbone register word addresses (PEND, MASK, ACT, CTRL)
//   - FSM state type and state constants (IDLE, REQ, SERV)
// ---------------------------------------------------------------------------
package v0_intc_pkg;

    typedef logic [1:0] intc_adr_t;

    localparam intc_adr_t INTC_PEND = 2'd0;  // pending bits, write-1-to-clear
    localparam intc_adr_t INTC_MASK = 2'd1;  // 1 enables the source
    localparam intc_adr_t INTC_ACT  = 2'd2;  // one-hot in-service, write = EOI
    localparam intc_adr_t INTC_CTRL = 2'd3;  // bit0 = global enable

    typedef logic [1:0] intc_state_t;

    localparam intc_state_t ST_IDLE = 2'd0;
    localparam intc_state_t ST_REQ  = 2'd1;
    localparam intc_state_t ST_SERV = 2'd2;

endpackage

// File: rtl/v0_intc_if.sv
// ---------------------------------------------------------------------------
// v0_intc_if
// Pipelined Wishbone slave bus used for software access to the controller.
//   wbcyc/wbstb/wbwe : cycle, strobe, write enable      (master -> slave)
//   wbadr            : register word address            (master -> slave)
//   wbin             : write data                       (master -> slave)
//   wback            : acknowledge, one cycle after stb (slave -> master)
//   wbstl            : stall, always 0                  (slave -> master)
//   wbout            : registered read data             (slave -> master)
// ---------------------------------------------------------------------------
interface v0_intc_if
    import v0_intc_pkg::*;
#(
    parameter int BW = 32
);
    logic          wbcyc;
    logic          wbstb;
    logic          wbwe;
    intc_adr_t     wbadr;
    logic [BW-1:0] wbin;
    logic          wback;
    logic          wbstl;
    logic [BW-1:0] wbout;

    modport master (
        output wbcyc, wbstb, wbwe, wbadr, wbin,
        input  wback, wbstl, wbout
    );

    modport slave (
        input  wbcyc, wbstb, wbwe, wbadr, wbin,
        output wback, wbstl, wbout
    );
endinterface

// File: rtl/v0_prienc.sv
// ---------------------------------------------------------------------------
// v0_prienc
// Combinational lowest-index priority encoder.
//   req_i   [NIRQ] : request vector, bit 0 has highest priority
//   num_o   [NW]   : index of the lowest set bit (0 when none set)
//   valid_o        : at least one request bit is set
// ---------------------------------------------------------------------------
module v0_prienc #(
    parameter int NIRQ = 8,
    parameter int NW   = 3
) (
    input  logic [NIRQ-1:0] req_i,
    output logic [NW-1:0]   num_o,
    output logic            valid_o
);
    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves
        // it unassigned and no latch is inferred.
        num_o   = '0;
        valid_o = |req_i;
        // Scan from the top down so the lowest set index is written last.
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                num_o = NW'(i);
            end
        end
    end
endmodule

// File: rtl/v0_intc.sv
// ---------------------------------------------------------------------------
// v0_intc
// Interrupt controller: edge-detects irq sources into PEND, masks them,
// selects the lowest-index eligible source and hands it to the CPU through
// a request/acknowledge handshake, holding it in service until EOI.
//   clk       : processor clock
//   rst       : asynchronous active-high reset
//   wb        : Wishbone slave (PEND/MASK/ACT/CTRL registers)
//   irqin_i   : source requests (pulses or levels), bit 0 highest priority
//   intreq_o  : interrupt request to the CPU
//   intnum_o  : requested source number, valid while intreq_o=1
//   intack_i  : CPU acknowledge, single-cycle pulse
// ---------------------------------------------------------------------------
module v0_intc
    import v0_intc_pkg::*;
#(
    parameter int NIRQ = 8,
    parameter int NW   = 3,
    parameter int BW   = 32
) (
    input  logic            clk,
    input  logic            rst,
    v0_intc_if.slave        wb,
    input  logic [NIRQ-1:0] irqin_i,
    output logic            intreq_o,
    output logic [NW-1:0]   intnum_o,
    input  logic            intack_i
);
    logic [NIRQ-1:0] irqprev_q;
    logic [NIRQ-1:0] pend_q, pend_d;
    logic [NIRQ-1:0] mask_q, mask_d;
    logic [NIRQ-1:0] act_q,  act_d;
    logic            ctrl_q, ctrl_d;
    intc_state_t     state_q, state_d;
    logic [NW-1:0]   intnum_q, intnum_d;
    logic            wback_q;
    logic [BW-1:0]   wbout_q, wbout_d;

    logic [NIRQ-1:0] rise;
    logic [NIRQ-1:0] eligible;
    logic [NIRQ-1:0] src_onehot;
    logic [NW-1:0]   enc_num;
    logic            enc_valid;
    logic            wr_en, rd_en;
    logic            wr_pend, wr_mask, wr_act, wr_ctrl;
    logic            take_ack;
    logic            latched_eligible;

    assign rise     = irqin_i & ~irqprev_q;
    assign eligible = pend_q & mask_q;

    assign wr_en   = wb.wbcyc & wb.wbstb & wb.wbwe;
    assign rd_en   = wb.wbstb & ~wb.wbwe;
    assign wr_pend = wr_en && (wb.wbadr == INTC_PEND);
    assign wr_mask = wr_en && (wb.wbadr == INTC_MASK);
    assign wr_act  = wr_en && (wb.wbadr == INTC_ACT);
    assign wr_ctrl = wr_en && (wb.wbadr == INTC_CTRL);

    assign src_onehot       = {{(NIRQ-1){1'b0}}, 1'b1} << intnum_q;
    assign take_ack         = (state_q == ST_REQ) && intack_i;
    assign latched_eligible = eligible[intnum_q] & ctrl_q;

    v0_prienc #(
        .NIRQ (NIRQ),
        .NW   (NW)
    ) u_prienc (
        .req_i   (eligible),
        .num_o   (enc_num),
        .valid_o (enc_valid)
    );

    // Request/service FSM. The source number is frozen on entry to REQ so a
    // later higher-priority arrival does not preempt the pending request.
    always_comb begin
        state_d  = state_q;
        intnum_d = intnum_q;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_q && enc_valid) begin
                    state_d  = ST_REQ;
                    intnum_d = enc_num;
                end
            end
            ST_REQ: begin
                if (intack_i) begin
                    state_d = ST_SERV;
                end else if (!latched_eligible) begin
                    state_d = ST_IDLE;  // retraction
                end
            end
            ST_SERV: begin
                if (wr_act) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // New edges win over a same-cycle W1C or acknowledge clear.
    always_comb begin
        pend_d = pend_q;
        if (wr_pend) begin
            pend_d = pend_d & ~wb.wbin[NIRQ-1:0];
        end
        if (take_ack) begin
            pend_d = pend_d & ~src_onehot;
        end
        pend_d = pend_d | rise;
    end

    always_comb begin
        mask_d = wr_mask ? wb.wbin[NIRQ-1:0] : mask_q;
        ctrl_d = wr_ctrl ? wb.wbin[0] : ctrl_q;
        act_d  = act_q;
        if (take_ack) begin
            act_d = src_onehot;
        end else if (wr_act) begin
            act_d = '0;
        end
    end

    // Read data is taken from the current registers, i.e. before any
    // same-cycle write lands.
    always_comb begin
        wbout_d = '0;
        case (wb.wbadr)
            INTC_PEND: wbout_d[NIRQ-1:0] = pend_q;
            INTC_MASK: wbout_d[NIRQ-1:0] = mask_q;
            INTC_ACT:  wbout_d[NIRQ-1:0] = act_q;
            INTC_CTRL: wbout_d[0]        = ctrl_q;
            default:   wbout_d           = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            intnum_q  <= '0;
            irqprev_q <= '0;
            pend_q    <= '0;
            mask_q    <= '0;
            act_q     <= '0;
            ctrl_q    <= 1'b0;
            wback_q   <= 1'b0;
            wbout_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q   <= state_d;
            intnum_q  <= intnum_d;
            irqprev_q <= irqin_i;
            pend_q    <= pend_d;
            mask_q    <= mask_d;
            act_q     <= act_d;
            ctrl_q    <= ctrl_d;
            wback_q   <= wb.wbstb;
            if (rd_en) begin
                wbout_q <= wbout_d;
            end
        end
    end

    // Decoded straight from the state register so an asynchronous reset
    // drops the request without waiting for a clock edge.
    assign intreq_o = (state_q == ST_REQ);
    assign intnum_o = intnum_q;

    assign wb.wback = wback_q;
    assign wb.wbstl = 1'b0;
    assign wb.wbout = wbout_q;

endmodule
